// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for serial_sub.
// Macro SERIAL_SUB_OVF_EN adds the ovf result signal.
interface serial_sub_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             b_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, b_in, input busy, done, d, b_out, ovf);
    modport slave  (input start, a, b, b_in, output busy, done, d, b_out, ovf);
`else
    modport master (output start, a, b, b_in, input busy, done, d, b_out);
    modport slave  (input start, a, b, b_in, output busy, done, d, b_out);
`endif
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor d = a - b - b_in, LSB first, one full-subtractor cell.
// Macro SERIAL_SUB_OVF_EN adds a signed-overflow flag held alongside d.
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_sub_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sd;
    logic [WIDTH-1:0] r_d;
    logic             r_br;
    logic             r_bout;
    logic [CW-1:0]    r_cnt;

    logic             w_x;
    logic             w_y;
    logic             w_diff;
    logic             w_br_next;
    logic [WIDTH-1:0] w_sd_next;
    logic             w_accept;
    logic             w_last;
    logic             w_busy;
    logic             w_done;

`ifdef SERIAL_SUB_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_ovf;
`endif

    assign w_x       = r_sa[0];
    assign w_y       = r_sb[0];
    assign w_diff    = w_x ^ w_y ^ r_br;
    assign w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
    assign w_sd_next = {w_diff, r_sd[WIDTH-1:1]};
    assign w_accept  = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last    = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = bus.start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_RUN:   w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // Result registers load from the next-value wires so the final bit lands on the completing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_sd    <= '0;
            r_d     <= '0;
            r_br    <= 1'b0;
            r_bout  <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_sa    <= bus.a;
            r_sb    <= bus.b;
            r_br    <= bus.b_in;
            r_sd    <= '0;
            r_cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
`endif
        end else if (r_state == S_RUN) begin
            r_sa <= r_sa >> 1;
            r_sb <= r_sb >> 1;
            r_br <= w_br_next;
            r_sd <= w_sd_next;
            if (w_last) begin
                r_d    <= w_sd_next;
                r_bout <= w_br_next;
`ifdef SERIAL_SUB_OVF_EN
                r_ovf  <= (r_a_msb != r_b_msb) && (w_sd_next[WIDTH-1] != r_a_msb);
`endif
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign bus.busy  = w_busy;
    assign bus.done  = w_done;
    assign bus.d     = r_d;
    assign bus.b_out = r_bout;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf   = r_ovf;
`endif
endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
Bit-serial WIDTH-bit subtractor with a start/busy/done handshake. It computes d = a - b - b_in one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the subtract-side counterpart to the combinational ripple-carry adder. Operands are latched at start, results are presented together at completion, and the block sits beside the adder in the arithmetic datapath for area-constrained builds.

Parameters:
WIDTH, 4, operand and result width in bits (≥2)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising edge, accepted only in IDLE or DONE
a  input  WIDTH  minuend; sampled on the accepting edge only
b  input  WIDTH  subtrahend; sampled on the accepting edge only
b_in  input  1  borrow in; sampled on the accepting edge only
busy  output  1  high while the operation is in progress (RUN)
done  output  1  one-cycle pulse; d and b_out are valid and new
d  output  WIDTH  difference, held until the next completion or reset
b_out  output  1  borrow out of the MSB, held alongside d

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, d=0, b_out=0; shift registers, borrow register and counter cleared. Release is synchronous to the next rising edge.
- States: IDLE, RUN, DONE.
- IDLE, start=1 → RUN. Latch a→sa and b→sb, b_in→br, cnt=0.
- IDLE, start=0 → stay in IDLE.
- RUN, each edge:
  - x = sa[0], y = sb[0]
  - diff bit = x^y^br
  - br ← (~x&y) | (~(x^y)&br)
  - diff bit shifts into the MSB of internal register sd; sa and sb shift right; cnt++
  - when cnt==WIDTH-1 on this edge: d ← final sd value, b_out ← final br, state ← DONE
- DONE: done=1 for exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation, no idle gap) → RUN.
  - otherwise → IDLE.
- busy = (state==RUN). busy and done are never high together.
- Latency: start accepted at edge E0; RUN edges E1..E_WIDTH; done and new d are visible after E_WIDTH. Initiation interval is WIDTH+1 cycles.
- d and b_out never show partial results; they change only on the completing edge or on reset.
- start while in RUN is ignored; latched operands are unaffected by input changes after the accepting edge.
- Arithmetic is modulo 2^WIDTH. b_out=1 iff a < b + b_in (unsigned).
- Reset asserted mid-RUN aborts the operation; no done pulse is produced; outputs return to reset values.
- cnt width = clog2(WIDTH); no wrap occurs beyond WIDTH-1.

Optional Feature:
Macro SERIAL_SUB_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0). Updated on the same edge as d:
  - ovf = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB])
  - this is two's-complement signed overflow, using the latched operand sign bits
  - held alongside d
- Undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
1. WIDTH=4. a=9, b=3, b_in=0, start for 1 cycle → busy for 4 cycles; done pulse 4 edges after acceptance; d=6, b_out=0.
2. a=3, b=9, b_in=0 → d=0xA, b_out=1. Then a=0, b=0, b_in=1 → d=0xF, b_out=1.
3. Back-to-back: start held high across DONE with a=5, b=2 then a=1, b=1 → first done gives d=3; second operation starts with no IDLE cycle; second done gives d=0, b_out=0, exactly 5 cycles later.
4. start pulsed during RUN with different operands (a=0xF, b=0) → ignored; result reflects the originally latched a=7, b=4 (d=3).
5. rst_n asserted asynchronously (mid-cycle) on the 2nd RUN cycle of a=0xC, b=0x5 → busy, done, d, b_out go to 0 immediately; no done pulse follows; a subsequent start with a=0xC, b=0x5 yields d=7.
6. With SERIAL_SUB_OVF_EN defined: a=0x8, b=0x1 → d=7, ovf=1. a=0x7, b=0x1 → d=6, ovf=0. a=0x7, b=0xF → d=8, ovf=1.
